// File: rtl/add_share_arb_if.sv
// Requester and result handshake bundle for the shared-adder arbiter.
// master = the requesters plus the result consumer; slave = the arbiter.
interface add_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_carry;
    logic [IDW-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_carry, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_carry, res_id
    );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters.
// A single output register holds {carry, sum, id}; a new grant is issued
// whenever that register is empty or being drained in the same cycle, so
// back-to-back traffic sustains one result per clock.
module add_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    add_share_arb_if.slave     bus,
    output logic               busy
);
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;

    // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    // The register is free when empty or when its content leaves this cycle.
    assign free          = !bus.res_valid || bus.res_ready;
    assign accept        = !rst && ena && free && gnt_found;
    assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    assign op_a = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign op_b = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign busy = bus.res_valid;

    // Result register and round-robin pointer; ptr only moves on an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_carry <= 1'b0;
            bus.res_id    <= '0;
            ptr           <= '0;
        end else if (accept) begin
            bus.res_valid <= 1'b1;
            bus.res_sum   <= sum[WIDTH-1:0];
            bus.res_carry <= sum[WIDTH];
            bus.res_id    <= gnt_idx;
            ptr           <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IDW'(1);
        end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
        end
    end
endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Round-robin scheduler that shares one WIDTH-bit adder (sum plus carry) among NREQ requesters.
- Each requester hands over an operand pair with a valid/ready handshake.
- The arbiter grants one requester per cycle and registers the sum.
- The result is presented on a single valid/ready result port, tagged with the requester index.
- Sits between the tile's input-sampling logic and the uo_out driver.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of res_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- ena  input  1  1 = new grants allowed; 0 = no new acceptance, pending result still drains.
- req_valid  input  NREQ  requester i presents an operand pair.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot or zero; high for the requester accepted this cycle.
- res_valid  output  1  result register holds an undelivered result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH  low WIDTH bits of a+b.
- res_carry  output  1  carry-out of a+b.
- res_id  output  IDW  index of the requester that produced the result.
- busy  output  1  equals res_valid (occupancy indicator).

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0.
  - Round-robin pointer ptr=0.
  - req_ready is forced to 0 while rst=1.
- Reset mid-operation: any held result is discarded; no handshake completes in the reset cycle.
- Register capacity:
  - Output register has one entry; there is no other buffering.
  - "Free" = !res_valid || res_ready.
- Grant (combinational):
  - When ena && free && |req_valid, g = first i with req_valid[i], scanning ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 and all other bits are 0.
  - Otherwise req_ready is all zero.
- Accept (req_valid[g] && req_ready[g] at a clock edge):
  - {res_carry,res_sum} <= req_a[g] + req_b[g], computed at WIDTH+1 bits with no truncation of the carry.
  - res_id <= g, res_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- Latency: result visible exactly 1 cycle after acceptance.
- Drain:
  - A res_valid && res_ready edge with no simultaneous accept sets res_valid <= 0.
  - Simultaneous drain and accept in the same cycle keeps res_valid=1 and loads the new result. Full throughput is one result per cycle.
- Hold: while res_valid && !res_ready, res_sum, res_carry and res_id are stable and req_ready is all zero.
- ptr changes only on an accept; it does not advance while stalled or idle.
- ena=0: req_ready all zero; a held result still drains on res_ready; ptr is unchanged.
- Requester rules:
  - Requesters must hold req_valid and operands stable until accepted.
  - Behaviour on withdrawal before acceptance is unspecified but must not corrupt a held result.
- Wrap: ptr wraps from NREQ-1 to 0. The sum wraps modulo 2**WIDTH, with the overflow reported only on res_carry.
- The block has no other state machine states: IDLE (res_valid=0) and FULL (res_valid=1) are fully described by res_valid.

Test Plan:
- Reset then single request: rst 1 for 2 cycles; req_valid=01, a0=0x12, b0=0x34, res_ready=1 -> req_ready=01 that cycle; next cycle res_valid=1, res_sum=0x46, res_carry=0, res_id=0; then res_valid=0.
- Carry: a1=0xFF, b1=0x02 on requester 1 only -> res_sum=0x01, res_carry=1, res_id=1.
- Round-robin fairness: both requesters continuously valid, res_ready=1 -> grants alternate 0,1,0,1; one result per cycle; res_id sequence 0,1,0,1 with correct sums.
- Backpressure: res_ready=0 for 3 cycles with both valid -> res_valid stays 1, outputs frozen, req_ready=00. Raise res_ready -> drain and next accept in the same cycle; the next grant goes to the requester not previously served.
- ena gating: ena=0 with req_valid=11 -> req_ready=00 and ptr unchanged. A previously held result drains when res_ready=1, then res_valid=0.
- Reset mid-operation: result held (res_valid=1, res_ready=0), assert rst one cycle -> res_valid=0, res_sum=0, res_id=0, ptr=0. The first grant after reset goes to requester 0 when both requesters are valid.
